// File: rtl/ad_capture_pkg.sv
// ad_capture_pkg: state encoding and default transmit pulse width for ad_capture_ctrl
package ad_capture_pkg;

    typedef enum logic [2:0] {IDLE, FIRE, DELAY, CAPTURE, DONE} state_t;

    localparam int FIRE_W_DEF = 4;

endpackage

// File: rtl/ad_capture_cnt.sv
// ad_capture_cnt: loadable down counter that stops at zero, shared by the timed phases
module ad_capture_cnt #(
    parameter int CNTW = 16
) (
    input  logic            wclk,
    input  logic            rst,
    input  logic            load,
    input  logic [CNTW-1:0] load_val,
    output logic [CNTW-1:0] cnt,
    output logic            zero
);

    assign zero = cnt == '0;

    // load on phase entry, otherwise count down and hold at zero
    always_ff @(posedge wclk or negedge rst)
        if (!rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (!zero)
            cnt <= cnt - 1'b1;

endmodule

// File: rtl/ad_capture_ctrl.sv
// ad_capture_ctrl: one-shot fire/delay/capture sequencer for the ADC sample FIFO write side
// Build option AD_CAPTURE_TESTPAT_EN replaces the captured samples with a per-shot ramp.
module ad_capture_ctrl
    import ad_capture_pkg::*;
#(
    parameter int DSIZE  = 10,
    parameter int CNTW   = 16,
    parameter int FIRE_W = FIRE_W_DEF
) (
    input  logic             wclk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNTW-1:0]  delay,
    input  logic [CNTW-1:0]  length,
    input  logic [DSIZE-1:0] adc_data,
    input  logic             fifo_full,
    output logic             pulse_fire,
    output logic             fifo_wreq,
    output logic [DSIZE-1:0] fifo_wdata,
    output logic             busy,
    output logic             done,
    output logic             overflow
);

    state_t          state, next;
    logic [CNTW-1:0] delay_q, len_q, load_val, cnt;
    logic            accept, load, zero;
    logic            pulse_d, wreq_d, busy_d, done_d;

    assign accept = state == IDLE && start && !abort;
    assign load   = next != state;

    // each timed phase reloads the shared counter with its length minus one; zero lengths still take one cycle
    assign load_val = next == FIRE    ? CNTW'(FIRE_W - 1) :
                      next == DELAY   ? (delay_q == '0 ? '0 : delay_q - 1'b1) :
                      next == CAPTURE ? (len_q == '0 ? '0 : len_q - 1'b1) : '0;

    ad_capture_cnt #(.CNTW(CNTW)) u_cnt (
        .wclk     (wclk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .cnt      (cnt),
        .zero     (zero)
    );

    // state register and shot parameters latched on an accepted start
    always_ff @(posedge wclk or negedge rst)
        if (!rst) begin
            state   <= IDLE;
            delay_q <= '0;
            len_q   <= '0;
        end else begin
            state <= next;
            if (accept) begin
                delay_q <= delay;
                len_q   <= length & ~CNTW'(1);
            end
        end

    // next-state: abort returns to IDLE from anywhere, timed phases advance when the counter is empty
    always_comb begin
        next = state;
        case (state)
            IDLE:    next = accept ? FIRE : IDLE;
            FIRE:    next = zero ? DELAY : FIRE;
            DELAY:   next = zero ? CAPTURE : DELAY;
            CAPTURE: next = zero ? DONE : CAPTURE;
            default: next = IDLE;
        endcase
        if (state != IDLE && abort)
            next = IDLE;
    end

    // outputs decoded from the next state so the registered copies line up with the state they describe
    always_comb begin
        pulse_d = next == FIRE;
        wreq_d  = next == CAPTURE && len_q != '0;
        busy_d  = next != IDLE;
        done_d  = next == DONE;
    end

    // registered control outputs; overflow is sticky until the next accepted start
    always_ff @(posedge wclk or negedge rst)
        if (!rst) begin
            pulse_fire <= 1'b0;
            fifo_wreq  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            pulse_fire <= pulse_d;
            fifo_wreq  <= wreq_d;
            busy       <= busy_d;
            done       <= done_d;
            if (accept)
                overflow <= 1'b0;
            else if (fifo_wreq && fifo_full)
                overflow <= 1'b1;
        end

`ifdef AD_CAPTURE_TESTPAT_EN
    logic [DSIZE-1:0] ramp;

    // ramp restarts at zero each shot and advances once per written sample
    always_ff @(posedge wclk or negedge rst)
        if (!rst) begin
            ramp       <= '0;
            fifo_wdata <= '0;
        end else if (accept) begin
            ramp <= '0;
        end else if (wreq_d) begin
            fifo_wdata <= ramp;
            ramp       <= ramp + 1'b1;
        end
`else
    // sample register: one stage, aligned with fifo_wreq
    always_ff @(posedge wclk or negedge rst)
        if (!rst)
            fifo_wdata <= '0;
        else
            fifo_wdata <= adc_data;
`endif

endmodule

// File: tb/tb_ad_capture_ctrl.sv
// tb_ad_capture_ctrl: directed shots checked every cycle against a schedule model plus literal timing pins
module tb_ad_capture_ctrl;

    localparam int FW = 4;
    localparam int DS = 10;
    localparam int CW = 16;

    logic          wclk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          fifo_full = 1'b0;
    logic [CW-1:0] delay = '0;
    logic [CW-1:0] length = '0;
    logic [DS-1:0] adc_data = '0;
    logic          pulse_fire, fifo_wreq, busy, done, overflow;
    logic [DS-1:0] fifo_wdata;

    int checks = 0;
    int errors = 0;

    ad_capture_ctrl #(.DSIZE(DS), .CNTW(CW), .FIRE_W(FW)) dut (
        .wclk       (wclk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .delay      (delay),
        .length     (length),
        .adc_data   (adc_data),
        .fifo_full  (fifo_full),
        .pulse_fire (pulse_fire),
        .fifo_wreq  (fifo_wreq),
        .fifo_wdata (fifo_wdata),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow)
    );

    always #5 wclk = ~wclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge wclk);
    endtask

    // drive a start for one cycle, then scramble the shot inputs to prove they were latched
    task automatic shot(input int d, input int l);
        delay  = CW'(d);
        length = CW'(l);
        start  = 1'b1;
        tick(1);
        start  = 1'b0;
        delay  = CW'($urandom);
        length = CW'($urandom);
    endtask

    // model: each shot is a schedule in cycles after the accepting edge
    bit            run = 1'b0;
    int            rel, sd, sn, cs, de;
    logic          m_pulse = 1'b0, m_wreq = 1'b0, m_busy = 1'b0, m_done = 1'b0, m_ovf = 1'b0;
    logic [DS-1:0] m_wdata = '0;

    initial forever begin
        @(posedge wclk or negedge rst);
        if (!rst) begin
            run = 1'b0;
            {m_pulse, m_wreq, m_busy, m_done, m_ovf} = '0;
            m_wdata = '0;
        end else begin
            if (m_wreq && fifo_full)
                m_ovf = 1'b1;
            if (run && abort)
                run = 1'b0;
            else if (run)
                rel++;
            else if (start && !abort) begin
                run   = 1'b1;
                rel   = 1;
                sd    = int'(delay);
                sn    = int'(length) & ~1;
                m_ovf = 1'b0;
            end
            if (run) begin
                cs = 1 + FW + (sd == 0 ? 1 : sd);
                de = cs + (sn == 0 ? 1 : sn);
                if (rel > de)
                    run = 1'b0;
            end
            m_busy  = run;
            m_pulse = run && rel <= FW;
            m_wreq  = run && rel >= cs && rel < cs + sn;
            m_done  = run && rel == de;
`ifdef AD_CAPTURE_TESTPAT_EN
            if (m_wreq)
                m_wdata = DS'(rel - cs);
`else
            m_wdata = adc_data;
`endif
        end
    end

    initial forever begin
        @(negedge wclk);
        if (rst) begin
            chk("pulse_fire", pulse_fire, m_pulse);
            chk("fifo_wreq", fifo_wreq, m_wreq);
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            chk("overflow", overflow, m_ovf);
            chk("fifo_wdata", fifo_wdata, m_wdata);
        end
    end

    initial forever begin
        @(negedge wclk);
        adc_data = adc_data + DS'(37);
    end

    initial begin
        int n;
        tick(2);
        chk("rst_pulse", pulse_fire, 0);
        chk("rst_wreq", fifo_wreq, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_wdata", fifo_wdata, 0);
        rst = 1'b1;
        tick(2);

        shot(3, 8);
        chk("basic_fire_t1", pulse_fire, 1);
        chk("basic_busy_t1", busy, 1);
        tick(3);
        chk("basic_fire_t4", pulse_fire, 1);
        tick(1);
        chk("basic_fire_t5", pulse_fire, 0);
        tick(2);
        chk("basic_wreq_t7", fifo_wreq, 0);
        tick(1);
        chk("basic_wreq_t8", fifo_wreq, 1);
        tick(7);
        chk("basic_wreq_t15", fifo_wreq, 1);
        tick(1);
        chk("basic_done_t16", done, 1);
        chk("basic_wreq_t16", fifo_wreq, 0);
        tick(1);
        chk("basic_busy_t17", busy, 0);
        tick(2);

        shot(2, 7);
        n = 0;
        repeat (25) begin
            if (fifo_wreq)
                n++;
            tick(1);
        end
        chk("odd_len_writes", n, 6);

        shot(0, 0);
        tick(5);
        chk("zero_done_t6", done, 0);
        tick(1);
        chk("zero_done_t7", done, 1);
        tick(1);
        chk("zero_busy_t8", busy, 0);
        tick(2);

        shot(1, 10);
        tick(8);
        chk("abort_wreq_t9", fifo_wreq, 1);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        chk("abort_wreq_t10", fifo_wreq, 0);
        chk("abort_busy_t10", busy, 0);
        n = 0;
        repeat (12) begin
            if (done)
                n++;
            tick(1);
        end
        chk("abort_no_done", n, 0);
        shot(3, 8);
        tick(15);
        chk("after_abort_done", done, 1);
        tick(3);

        shot(3, 8);
        tick(2);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(4);
        chk("busy_start_wreq_t8", fifo_wreq, 1);
        tick(8);
        chk("busy_start_done_t16", done, 1);
        tick(1);
        chk("busy_start_idle_t17", busy, 0);
        tick(1);

        delay  = CW'(3);
        length = CW'(8);
        start  = 1'b1;
        abort  = 1'b1;
        tick(1);
        start  = 1'b0;
        abort  = 1'b0;
        chk("start_abort_busy", busy, 0);
        chk("start_abort_fire", pulse_fire, 0);
        tick(2);

        shot(2, 4);
        tick(8);
        fifo_full = 1'b1;
        tick(1);
        fifo_full = 1'b0;
        chk("ovf_set", overflow, 1);
        chk("ovf_4th_write", fifo_wreq, 1);
        tick(5);
        chk("ovf_sticky", overflow, 1);
        shot(3, 8);
        chk("ovf_cleared", overflow, 0);
        tick(18);

        shot(2, 6);
        tick(6);
`ifdef AD_CAPTURE_TESTPAT_EN
        chk("ramp_first", fifo_wdata, 0);
`endif
        chk("ramp_wreq_first", fifo_wreq, 1);
        tick(5);
`ifdef AD_CAPTURE_TESTPAT_EN
        chk("ramp_last", fifo_wdata, 5);
`endif
        chk("ramp_wreq_last", fifo_wreq, 1);
        tick(4);

        shot(20, 4);
        tick(8);
        #2 rst = 1'b0;
        #1;
        chk("async_pulse", pulse_fire, 0);
        chk("async_wreq", fifo_wreq, 0);
        chk("async_busy", busy, 0);
        chk("async_done", done, 0);
        chk("async_ovf", overflow, 0);
        chk("async_wdata", fifo_wdata, 0);
        tick(2);
        rst = 1'b1;
        tick(2);
        shot(3, 8);
        tick(15);
        chk("post_reset_done", done, 1);
        tick(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
